// File: rtl/mac_params.sv
// -----------------------------------------------------------------------------
// mac_params
// Shared MAC datapath constants and types.
//   N_SYMBOLS / W_SYMBOL : AXI-Stream beat geometry (8 bytes of 8 bits)
//   RX_FIFO_DEPTH_DEF    : default RX packet FIFO depth in 64-bit words
//   rx_fifo_word_t       : one stored beat {tlast, tkeep, tdata}
//   rx_wr_state_e        : RX FIFO write-side state
// -----------------------------------------------------------------------------
package mac_params;

    localparam int N_SYMBOLS         = 8;
    localparam int W_SYMBOL          = 8;
    localparam int RX_FIFO_DEPTH_DEF = 512;

    typedef struct packed {
        logic                                 tlast;
        logic [N_SYMBOLS-1:0]                 tkeep;
        logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]   tdata;
    } rx_fifo_word_t;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } rx_wr_state_e;

endpackage

// File: rtl/mac_rx_fifo_ram.sv
// -----------------------------------------------------------------------------
// mac_rx_fifo_ram
// Simple dual-port RAM for the RX packet FIFO: one write port, one read port
// with a registered (1-cycle) read. The array has no reset.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : read request; o_rdata valid the cycle after i_re
//   o_rdata          : registered read data (holds when i_re is low)
// -----------------------------------------------------------------------------
module mac_rx_fifo_ram
    import mac_params::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  rx_fifo_word_t              i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output rx_fifo_word_t              o_rdata
);

    rx_fifo_word_t mem [DEPTH];
    rx_fifo_word_t rdata_q;

    // NOTE: the storage array is deliberately left without a reset so it maps
    // onto block RAM; pointer/valid flops guard against reading stale words.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mac_rx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// mac_rx_pkt_fifo
// Store-and-forward packet FIFO behind the MAC RX AXI-Stream master (which has
// no backpressure). Whole frames are buffered; frames flagged bad (tuser on the
// last beat) or that would overflow are discarded. Only complete good frames
// are released on the backpressured master side.
//   i_clk, i_reset_n (async, active-low), i_clk_en (write-side qualifier)
//   s_axis_*   : input stream from MAC RX (no tready)
//   m_axis_*   : output stream toward user logic
//   o_err_drop_cnt / o_ovf_drop_cnt : saturating drop counters
//   o_level    : committed words not yet read from the RAM
// Build option: define MAC_RX_FIFO_STATS_EN to implement the drop counters;
// otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module mac_rx_pkt_fifo
    import mac_params::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF,
    parameter int W_CNT = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_clk_en,
    input  logic                            s_axis_tvalid,
    input  logic [N_SYMBOLS-1:0]            s_axis_tkeep,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0]   s_axis_tdata,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic [N_SYMBOLS-1:0]            m_axis_tkeep,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]   m_axis_tdata,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [W_CNT-1:0]                o_err_drop_cnt,
    output logic [W_CNT-1:0]                o_ovf_drop_cnt,
    output logic [$clog2(DEPTH):0]          o_level
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    rx_wr_state_e  wr_state_q, wr_state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic          rdata_vld_q, rdata_vld_d;
    logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    rx_fifo_word_t out_q, out_d, skid_q, skid_d;

    logic          wr_beat, full, empty, ram_we, rd_issue, pop;
    logic          err_inc, ovf_inc;
    logic [1:0]    held;
    rx_fifo_word_t wr_word, ram_rdata;

    assign wr_beat       = s_axis_tvalid & i_clk_en;
    // Registered rd_ptr: a read in this cycle does not free space until next.
    assign full          = (wr_ptr_q - rd_ptr_q) == DEPTH_W;
    assign empty         = (rd_ptr_q == wr_cmt_q);
    assign wr_word.tlast = s_axis_tlast;
    assign wr_word.tkeep = s_axis_tkeep;
    assign wr_word.tdata = s_axis_tdata;

    // Write side: tentative pointer advances per beat, committed pointer only
    // on a good last beat; dropped frames rewind to the committed pointer.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        ram_we     = 1'b0;
        err_inc    = 1'b0;
        ovf_inc    = 1'b0;
        if (wr_beat) begin
            case (wr_state_q)
                WR_ACCEPT: begin
                    if (full) begin
                        // Overflow wins over a tuser error on the same beat.
                        wr_ptr_d = wr_cmt_q;
                        ovf_inc  = 1'b1;
                        if (!s_axis_tlast) wr_state_d = WR_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_ptr_d = wr_cmt_q;
                                err_inc  = 1'b1;
                            end else begin
                                wr_cmt_d = wr_ptr_q + PTR_ONE;
                            end
                        end
                    end
                end
                WR_DROP: if (s_axis_tlast) wr_state_d = WR_ACCEPT;
                default: wr_state_d = WR_ACCEPT;
            endcase
        end
    end

    // Read side: RAM read (1 cycle) feeding a 2-entry output skid. A read is
    // issued only if the word will have a slot: out + skid + in-flight, minus
    // what leaves this cycle, must stay below two.
    always_comb begin
        pop         = out_vld_q & m_axis_tready;
        held        = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rdata_vld_q) - 2'(pop);
        rd_issue    = !empty && (held < 2'd2);
        rd_ptr_d    = rd_ptr_q + (rd_issue ? PTR_ONE : '0);
        rdata_vld_d = rd_issue;
        out_vld_d   = out_vld_q;
        out_d       = out_q;
        skid_vld_d  = skid_vld_q;
        skid_d      = skid_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = skid_q;
                skid_vld_d = rdata_vld_q;
                if (rdata_vld_q) skid_d = ram_rdata;
            end else if (rdata_vld_q) begin
                out_vld_d = 1'b1;
                out_d     = ram_rdata;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (rdata_vld_q) begin
            skid_vld_d = 1'b1;
            skid_d     = ram_rdata;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update
    // together at the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_state_q  <= WR_ACCEPT;
            wr_ptr_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            rdata_vld_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            rdata_vld_q <= rdata_vld_d;
            out_vld_q   <= out_vld_d;
            out_q       <= out_d;
            skid_vld_q  <= skid_vld_d;
            skid_q      <= skid_d;
        end
    end

    mac_rx_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (wr_ptr_q[AW-1:0]),
        .i_wdata (wr_word),
        .i_re    (rd_issue),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (ram_rdata)
    );

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_q.tlast;
    assign m_axis_tkeep  = out_q.tkeep;
    assign m_axis_tdata  = out_q.tdata;
    assign o_level       = wr_cmt_q - rd_ptr_q;

`ifdef MAC_RX_FIFO_STATS_EN
    logic [W_CNT-1:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

    // Saturating counters: hold at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + W_CNT'(1);
        if (ovf_inc && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + W_CNT'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_err_drop_cnt = err_cnt_q;
    assign o_ovf_drop_cnt = ovf_cnt_q;
`else
    logic unused_stat_inc;
    assign unused_stat_inc = err_inc | ovf_inc;
    assign o_err_drop_cnt  = '0;
    assign o_ovf_drop_cnt  = '0;
`endif

endmodule
